// File: rtl/bimc_chain_master.sv
// bimc_chain_master: originating end of the BIMC serial daisy chain (frame out, frame back, timeout).
// Define BIMC_CHAIN_MASTER_PARITY_EN to append/check an even-parity bit on every frame.
module bimc_chain_master #(
  parameter int FRAME_W = 32,
  parameter int TIMEOUT = 1024,
  parameter int RST_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               rsp_timeout,
  output logic               rsp_perr,
  output logic               bimc_odat,
  output logic               bimc_osync,
  input  logic               bimc_idat,
  input  logic               bimc_isync,
  output logic               bimc_rst_n
);
`ifdef BIMC_CHAIN_MASTER_PARITY_EN
  localparam int L = FRAME_W + 1;
`else
  localparam int L = FRAME_W;
`endif
  localparam int CW  = $clog2(L + 1);
  localparam int RCW = (RST_CYC > 0) ? $clog2(RST_CYC + 1) : 1;

  // CRST: chain reset held | IDLE: ready for command | SHIFT: frame going out | WAIT: awaiting return
  typedef enum logic [1:0] {S_CRST, S_IDLE, S_SHIFT, S_WAIT} state_t;

  state_t state_q, state_d;

  logic [RCW-1:0]     rst_cnt_q;
  logic [L-1:0]       tx_sh_q;
  logic [CW-1:0]      tx_cnt_q;
  logic [L-1:0]       rx_sh_q;
  logic [CW-1:0]      rx_cnt_q;
  logic               rx_armed_q, rx_busy_q, rx_done_q;
  logic [15:0]        tmo_q;

  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [FRAME_W-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               rsp_perr_q, rsp_perr_d;
  logic               odat_q, odat_d;
  logic               osync_q, osync_d;
  logic               chain_rst_n_q, chain_rst_n_d;

  logic [L-1:0]       tx_frame;
  logic               accept, rx_start, rx_last, tmo_hit, rsp_fire;

`ifdef BIMC_CHAIN_MASTER_PARITY_EN
  assign tx_frame = {^cmd_data, cmd_data};
`else
  assign tx_frame = cmd_data;
`endif

  assign accept   = cmd_valid & cmd_ready_q;
  assign rx_start = rx_armed_q & ~rx_busy_q & bimc_isync;
  assign rx_last  = rx_busy_q & (rx_cnt_q == CW'(1));
  // A capture already running always wins over an expiring timer.
  assign tmo_hit  = (state_q == S_WAIT) & ~rx_busy_q & ~rx_done_q & ~rx_start & (tmo_q == 16'd0);
  assign rsp_fire = (state_q == S_WAIT) & (rx_done_q | tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_CRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CRST:  if (rst_cnt_q == '0)  state_d = S_IDLE;
      S_IDLE:  if (accept)           state_d = S_SHIFT;
      S_SHIFT: if (tx_cnt_q == '0)   state_d = S_WAIT;
      S_WAIT:  if (rsp_fire)         state_d = S_IDLE;
      default:                       state_d = S_CRST;
    endcase
  end

  always_comb begin
    cmd_ready_d   = (state_q == S_IDLE) & ~accept;
    chain_rst_n_d = chain_rst_n_q | ((state_q == S_CRST) & (rst_cnt_q == '0));
    osync_d       = accept;
    odat_d        = 1'b0;
    if (accept)
      odat_d = cmd_data[0];
    else if ((state_q == S_SHIFT) && (tx_cnt_q != '0))
      odat_d = tx_sh_q[0];
    rsp_valid_d   = rsp_fire;
    rsp_timeout_d = rsp_fire & ~rx_done_q;
    rsp_data_d    = (rsp_fire & rx_done_q) ? rx_sh_q[FRAME_W-1:0] : rsp_data_q;
`ifdef BIMC_CHAIN_MASTER_PARITY_EN
    rsp_perr_d    = rsp_fire & rx_done_q & (^rx_sh_q);
`else
    rsp_perr_d    = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_perr_q    <= 1'b0;
      odat_q        <= 1'b0;
      osync_q       <= 1'b0;
      chain_rst_n_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_perr_q    <= rsp_perr_d;
      odat_q        <= odat_d;
      osync_q       <= osync_d;
      chain_rst_n_q <= chain_rst_n_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q  <= RCW'(RST_CYC);
      tx_sh_q    <= '0;
      tx_cnt_q   <= '0;
      tmo_q      <= '0;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      rx_armed_q <= 1'b0;
      rx_busy_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      if ((state_q == S_CRST) && (rst_cnt_q != '0))
        rst_cnt_q <= rst_cnt_q - 1'b1;

      if (accept) begin
        tx_sh_q  <= tx_frame >> 1;
        tx_cnt_q <= CW'(L - 1);
      end else if ((state_q == S_SHIFT) && (tx_cnt_q != '0)) begin
        tx_sh_q  <= tx_sh_q >> 1;
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end

      if (accept)
        tmo_q <= 16'(TIMEOUT - 1);
      else if (tmo_q != 16'd0)
        tmo_q <= tmo_q - 16'd1;

      // Receiver is armed in the osync cycle so a zero-latency chain is still caught.
      if (accept) begin
        rx_armed_q <= 1'b1;
        rx_busy_q  <= 1'b0;
        rx_done_q  <= 1'b0;
      end else begin
        if (rx_start) begin
          rx_armed_q <= 1'b0;
          rx_busy_q  <= 1'b1;
          rx_cnt_q   <= CW'(L - 1);
          rx_sh_q    <= {bimc_idat, rx_sh_q[L-1:1]};
        end else if (rx_busy_q) begin
          rx_sh_q  <= {bimc_idat, rx_sh_q[L-1:1]};
          rx_cnt_q <= rx_cnt_q - 1'b1;
          if (rx_last) begin
            rx_busy_q <= 1'b0;
            rx_done_q <= 1'b1;
          end
        end
        if (rsp_fire) begin
          rx_armed_q <= 1'b0;
          rx_done_q  <= 1'b0;
        end
      end
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_perr    = rsp_perr_q;
  assign bimc_odat   = odat_q;
  assign bimc_osync  = osync_q;
  assign bimc_rst_n  = chain_rst_n_q;

endmodule
